// File: rtl/prim_mem_responder.sv
// prim_mem_responder
// Responder side of the Prim CPU memory bus. It serves fetch, load and store
// requests from an internal word-addressed RAM. Each access is captured in IDLE,
// held for WAIT_STATES cycles, and acknowledged for exactly one cycle. After the
// ACK cycle there is always one IDLE turnaround cycle. Writes use per-byte
// selects. Words below PROT_WORDS are boot code and cannot be written.

module prim_mem_responder #(
   parameter int unsigned ADDR_W      = 12,  // RAM depth = 2**ADDR_W words
   parameter int unsigned WAIT_STATES = 1,   // extra cycles before ack, 0..15
   parameter int unsigned PROT_WORDS  = 0    // words 0..PROT_WORDS-1 read-only
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic [15:0] i_addr,
   input  logic [15:0] i_dat,
   output logic [15:0] o_dat,
   input  logic [1:0]  i_bs,
   input  logic        i_we,
   output logic        o_ack,
   output logic        o_wp_err
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [3:0]  WS    = WAIT_STATES[3:0];

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;

   logic [1:0]        state, state_nxt;
   logic [3:0]        wait_cnt;
   logic [ADDR_W-1:0] cap_addr;
   logic [15:0]       cap_dat;
   logic [1:0]        cap_bs;
   logic              cap_we;
   logic [15:0]       dat_q;
   logic              prot_hit;
   logic              req;
   logic [ADDR_W-1:0] rd_addr;

   logic [15:0] mem [DEPTH];

   // Address bits above the RAM depth alias onto the low words.
   generate
      if (ADDR_W < 16) begin : g_alias
         logic unused_addr_hi;
         assign unused_addr_hi = ^i_addr[15:ADDR_W];
      end
   endgenerate

   // A write to the boot region is acked, but it never reaches the RAM.
   generate
      if (PROT_WORDS == 0) begin : g_no_prot
         assign prot_hit = 1'b0;
      end else begin : g_prot
         assign prot_hit = ({{(32-ADDR_W){1'b0}}, cap_addr} < PROT_WORDS);
      end
   endgenerate

   assign req = (i_bs != 2'b00);

   // When WAIT_STATES is zero, the read happens while the request is being
   // captured, so the address comes straight from the bus. Otherwise it comes
   // from the captured copy.
   assign rd_addr = (state == ST_IDLE) ? i_addr[ADDR_W-1:0] : cap_addr;

   // Next-state selection for the IDLE -> WAIT -> ACK -> IDLE sequence.
   always_comb begin
      // NOTE: assign a default first so that no path leaves state_nxt unassigned.
      //       An unassigned path would infer a latch.
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (req) begin
               state_nxt = (WS == 4'd0) ? ST_ACK : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (wait_cnt <= 4'd1) begin
               state_nxt = ST_ACK;
            end
         end
         ST_ACK:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register and wait counter. Reset aborts any access in flight.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      // NOTE: use non-blocking assignments here. Every register then samples
      //       pre-edge values, whatever order the blocks are evaluated in.
      if (!i_reset_n) begin
         state    <= ST_IDLE;
         wait_cnt <= 4'd0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: if (req) wait_cnt <= WS;
            ST_WAIT: if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
            default: wait_cnt <= wait_cnt;
         endcase
      end
   end

   // Capture the request in IDLE. From then on the bus is ignored until the
   // access completes.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cap_addr <= '0;
         cap_dat  <= 16'h0000;
         cap_bs   <= 2'b00;
         cap_we   <= 1'b0;
      end else if (state == ST_IDLE && req) begin
         cap_addr <= i_addr[ADDR_W-1:0];
         cap_dat  <= i_dat;
         cap_bs   <= i_bs;
         cap_we   <= i_we;
      end
   end

   // Load the read word on the edge that enters ACK. On a write ack this gives
   // the word's contents before the write. The value is held until the next ack.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         dat_q <= 16'h0000;
      end else if (state_nxt == ST_ACK && state != ST_ACK) begin
         dat_q <= mem[rd_addr];
      end
   end

   // Commit the write on the edge that ends ACK, updating only the selected
   // bytes. While reset is low, state is IDLE, so an aborted write never lands.
   always_ff @(posedge i_clk) begin
      // NOTE: RAM contents are deliberately not reset. Leaving it out of the
      //       reset keeps the array mappable onto a plain memory macro.
      if (state == ST_ACK && cap_we && !prot_hit) begin
         if (cap_bs[1]) mem[cap_addr][15:8] <= cap_dat[15:8];
         if (cap_bs[0]) mem[cap_addr][7:0]  <= cap_dat[7:0];
      end
   end

   assign o_dat    = dat_q;
   assign o_ack    = (state == ST_ACK);
   assign o_wp_err = (state == ST_ACK) && cap_we && prot_hit;

endmodule

// File: tb/tb_prim_mem_responder.sv
// tb_prim_mem_responder
// Three responders share one clock and reset:
//   d0: WAIT_STATES=0, no protection
//   d1: WAIT_STATES=3, no protection
//   d2: WAIT_STATES=1, PROT_WORDS=16
// Each access is checked against a memory model that tracks which bytes are
// known. Words the bench has never written are learned from their first
// observation, and every later access is predicted.

module tb_prim_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n = 1'b1;
   logic [15:0] addr [3];
   logic [15:0] wdat [3];
   logic [15:0] rdat [3];
   logic [1:0]  bs   [3];
   logic        we   [3];
   logic        ack  [3];
   logic        wp   [3];

   int ws_of   [3] = '{0, 3, 1};
   int prot_of [3] = '{0, 0, 16};

   logic [15:0] mdl   [3][4096];
   logic [1:0]  known [3][4096];

   int n_checks = 0;
   int n_pass   = 0;

   prim_mem_responder #(.ADDR_W(12), .WAIT_STATES(0), .PROT_WORDS(0)) u_d0 (
      .i_clk(clk), .i_reset_n(reset_n), .i_addr(addr[0]), .i_dat(wdat[0]),
      .o_dat(rdat[0]), .i_bs(bs[0]), .i_we(we[0]), .o_ack(ack[0]), .o_wp_err(wp[0]));

   prim_mem_responder #(.ADDR_W(12), .WAIT_STATES(3), .PROT_WORDS(0)) u_d1 (
      .i_clk(clk), .i_reset_n(reset_n), .i_addr(addr[1]), .i_dat(wdat[1]),
      .o_dat(rdat[1]), .i_bs(bs[1]), .i_we(we[1]), .o_ack(ack[1]), .o_wp_err(wp[1]));

   prim_mem_responder #(.ADDR_W(12), .WAIT_STATES(1), .PROT_WORDS(16)) u_d2 (
      .i_clk(clk), .i_reset_n(reset_n), .i_addr(addr[2]), .i_dat(wdat[2]),
      .o_dat(rdat[2]), .i_bs(bs[2]), .i_we(we[2]), .o_ack(ack[2]), .o_wp_err(wp[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   // Performs one bus access on responder d and checks latency, pulse width,
   // wp_err and data against the model. The bus is scrambled after capture.
   task automatic access(input int d, input logic w, input logic [15:0] a,
                         input logic [15:0] wd, input logic [1:0] b,
                         output logic [15:0] rd);
      logic [11:0] k;
      logic [15:0] mask;
      logic        prot;
      int          lat;
      bit          got;
      k    = a[11:0];
      prot = w && (int'(k) < prot_of[d]);
      rd   = 16'h0000;
      @(negedge clk);
      addr[d] = a; wdat[d] = wd; bs[d] = b; we[d] = w;
      @(posedge clk);
      #1;
      addr[d] = 16'($urandom); wdat[d] = 16'($urandom);
      bs[d]   = 2'($urandom_range(1, 3)); we[d] = 1'($urandom_range(0, 1));
      got = 0; lat = 0;
      for (int c = 1; c <= ws_of[d] + 4 && !got; c++) begin
         @(negedge clk);
         if (ack[d]) begin got = 1; lat = c; end
      end
      if (!got) begin
         check($sformatf("d%0d_ack_timeout", d), 32'd0, 32'd1);
         bs[d] = 2'b00;
         return;
      end
      check($sformatf("d%0d_latency", d), lat, ws_of[d] + 1);
      check($sformatf("d%0d_wp_err", d), wp[d], prot);
      rd   = rdat[d];
      mask = {{8{known[d][k][1]}}, {8{known[d][k][0]}}};
      if (mask != 16'h0000)
         check($sformatf("d%0d_rdata@%0h", d, k), rd & mask, mdl[d][k] & mask);
      mdl[d][k]   = (mdl[d][k] & mask) | (rd & ~mask);
      known[d][k] = 2'b11;
      if (w && !prot) begin
         if (b[1]) mdl[d][k][15:8] = wd[15:8];
         if (b[0]) mdl[d][k][7:0]  = wd[7:0];
      end
      bs[d] = 2'b00;
      @(negedge clk);
      check($sformatf("d%0d_ack_pulse", d), ack[d], 1'b0);
      check($sformatf("d%0d_wp_idle", d), wp[d], 1'b0);
   endtask

   initial begin
      logic [15:0] rd;
      for (int d = 0; d < 3; d++) begin
         addr[d] = 16'h0000; wdat[d] = 16'h0000; bs[d] = 2'b00; we[d] = 1'b0;
         for (int k = 0; k < 4096; k++) begin
            mdl[d][k] = 16'h0000; known[d][k] = 2'b00;
         end
      end

      // Reset state
      #1 reset_n = 1'b0;
      #2;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("d%0d_rst_ack", d), ack[d], 1'b0);
         check($sformatf("d%0d_rst_wp", d), wp[d], 1'b0);
         check($sformatf("d%0d_rst_dat", d), rdat[d], 16'h0000);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Zero wait states: full write, then a read with one byte select
      access(0, 1'b1, 16'd5, 16'hBEEF, 2'b11, rd);
      access(0, 1'b0, 16'd5, 16'h0000, 2'b01, rd);
      check("t1_read", rd, 16'hBEEF);

      // Byte writes
      access(0, 1'b1, 16'd7, 16'h1234, 2'b11, rd);
      access(0, 1'b1, 16'd7, 16'hAB00, 2'b10, rd);
      check("t2_prewrite_dat", rd, 16'h1234);
      access(0, 1'b0, 16'd7, 16'h0000, 2'b11, rd);
      check("t2_hi_byte", rd, 16'hAB34);
      access(0, 1'b1, 16'd7, 16'h00CD, 2'b01, rd);
      access(0, 1'b0, 16'd7, 16'h0000, 2'b11, rd);
      check("t2_lo_byte", rd, 16'hABCD);

      // Three wait states; the bus is scrambled while the access waits
      access(1, 1'b1, 16'd9, 16'h3C3C, 2'b11, rd);
      access(1, 1'b0, 16'd9, 16'h0000, 2'b10, rd);
      check("t3_read", rd, 16'h3C3C);

      // Protected region
      access(2, 1'b1, 16'd3, 16'h5555, 2'b11, rd);
      access(2, 1'b0, 16'd3, 16'h0000, 2'b11, rd);
      access(2, 1'b1, 16'd16, 16'h5555, 2'b11, rd);
      access(2, 1'b0, 16'd16, 16'h0000, 2'b11, rd);
      check("t4_unprot_store", rd, 16'h5555);

      // Address aliasing
      access(0, 1'b1, 16'h1002, 16'h0F0F, 2'b11, rd);
      access(0, 1'b0, 16'h0002, 16'h0000, 2'b11, rd);
      check("t5_alias", rd, 16'h0F0F);

      // Reset while a write is in WAIT
      access(1, 1'b1, 16'd40, 16'hA5A5, 2'b11, rd);
      @(negedge clk);
      addr[1] = 16'd40; wdat[1] = 16'h1111; bs[1] = 2'b11; we[1] = 1'b1;
      @(posedge clk);
      #1 bs[1] = 2'b00;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("t6_rst_ack", ack[1], 1'b0);
      check("t6_rst_dat", rdat[1], 16'h0000);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("t6_no_late_ack", ack[1], 1'b0);
      end
      access(1, 1'b0, 16'd40, 16'h0000, 2'b11, rd);
      check("t6_word_kept", rd, 16'hA5A5);

      // Randomized traffic against the model
      for (int d = 0; d < 3; d++) begin
         for (int n = 0; n < 60; n++) begin
            access(d, 1'($urandom_range(0, 1)),
                   {4'($urandom_range(0, 15)), 12'($urandom_range(0, 31))},
                   16'($urandom), 2'($urandom_range(1, 3)), rd);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Hard stop in case the run stalls
   initial begin
      #500000;
      $display("FAIL global_timeout: got stalled expected finish");
      $fatal(1);
   end

endmodule
